// File: rtl/com_fifo_ctrl.sv
// Buffered COM-port controller: RX/TX byte FIFOs behind a DATA/STATUS register pair,
// a level interrupt, and an FSM that feeds queued TX bytes to the transmitter.
module com_fifo_ctrl #(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic        clkMain,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic        mode_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        int_o,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o
);
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [RX_DEPTH_LOG2:0] RX_FULL = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL = {1'b1, {TX_DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAITB, TX_WAITD} tx_state_t;

    tx_state_t                tx_state;
    logic [1:0]               wait_cnt;
    logic                     en_q, rxd_q, rd_q, mode_q;
    logic                     rx_overrun, tx_overflow;
    logic [1:0]               int_en;
    logic [7:0]               rx_mem [RX_DEPTH];
    logic [7:0]               tx_mem [TX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] rx_wr, rx_rd;
    logic [TX_DEPTH_LOG2-1:0] tx_wr, tx_rd;
    logic [RX_DEPTH_LOG2:0]   rx_count;
    logic [TX_DEPTH_LOG2:0]   tx_count;

    logic first_cyc, acc_end, status_rd_end;
    logic rx_strobe, rx_nonempty, rx_full, rx_push, rx_pop;
    logic tx_wr_req, tx_nonempty, tx_full, tx_push, tx_pop, tx_idle;
    logic [31:0] status_word;
    logic unused_bits;

    // Kind of access is taken from the first cycle so the end-of-access pop/clear
    // does not depend on what the CPU drives once enable_i has dropped.
    assign first_cyc     = enable_i & ~en_q;
    assign acc_end       = ~enable_i & en_q;
    assign status_rd_end = acc_end & rd_q & mode_q;

    assign rx_strobe   = rxdReady_i & ~rxd_q;
    assign rx_nonempty = (rx_count != '0);
    assign rx_full     = (rx_count == RX_FULL);
    assign rx_pop      = acc_end & rd_q & ~mode_q & rx_nonempty;
    assign rx_push     = rx_strobe & (~rx_full | rx_pop);

    assign tx_wr_req   = first_cyc & ~readEnable_i & ~mode_i;
    assign tx_nonempty = (tx_count != '0);
    assign tx_full     = (tx_count == TX_FULL);
    assign tx_pop      = (tx_state == TX_IDLE) & tx_nonempty & ~txdBusy_i;
    assign tx_push     = tx_wr_req & (~tx_full | tx_pop);
    assign tx_idle     = ~tx_nonempty & (tx_state == TX_IDLE) & ~txdBusy_i;

    assign status_word = {8'h00, 8'(tx_count), 8'(rx_count), 1'b0, int_en,
                          tx_overflow, tx_idle, rx_overrun, rx_nonempty, ~tx_full};
    assign unused_bits = ^dataSave_i[31:8];

    always_comb begin
        dataLoad_o = '0;
        if (mode_i) begin
            dataLoad_o = status_word;
        end else if (rx_nonempty) begin
            dataLoad_o = {24'h000000, rx_mem[rx_rd]};
        end
    end

    always_ff @(posedge clkMain) begin
        if (rx_push) rx_mem[rx_wr] <= rxdData_i;
        if (tx_push) tx_mem[tx_wr] <= dataSave_i[7:0];
    end

    always_ff @(posedge clkMain) begin
        if (rst) begin
            en_q        <= 1'b0;
            rxd_q       <= 1'b0;
            rd_q        <= 1'b0;
            mode_q      <= 1'b0;
            rx_wr       <= '0;
            rx_rd       <= '0;
            rx_count    <= '0;
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_count    <= '0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            int_en      <= 2'b01;
            int_o       <= 1'b0;
        end else begin
            en_q  <= enable_i;
            rxd_q <= rxdReady_i;
            if (first_cyc) begin
                rd_q   <= readEnable_i;
                mode_q <= mode_i;
            end
            if (first_cyc & ~readEnable_i & mode_i) int_en <= dataSave_i[1:0];

            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase

            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase

            // A new drop in the same cycle as the clearing read stays visible.
            if (status_rd_end) begin
                rx_overrun  <= 1'b0;
                tx_overflow <= 1'b0;
            end
            if (rx_strobe & rx_full & ~rx_pop) rx_overrun <= 1'b1;
            if (tx_wr_req & tx_full & ~tx_pop) tx_overflow <= 1'b1;

            int_o <= (int_en[0] & rx_nonempty) | (int_en[1] & tx_idle);
        end
    end

    // The head byte is popped on the IDLE->SEND edge, so txdData_o holds it while the strobe is high.
    always_ff @(posedge clkMain) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            wait_cnt   <= '0;
            txdStart_o <= 1'b0;
            txdData_o  <= '0;
        end else begin
            txdStart_o <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state   <= TX_SEND;
                        txdStart_o <= 1'b1;
                        txdData_o  <= tx_mem[tx_rd];
                    end
                end
                TX_SEND: begin
                    tx_state <= TX_WAITB;
                    wait_cnt <= '0;
                end
                TX_WAITB: begin
                    if (txdBusy_i) begin
                        tx_state <= TX_WAITD;
                    end else if (wait_cnt == 2'd3) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                TX_WAITD: begin
                    if (!txdBusy_i) tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule
